// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
//   Shared definitions for the system RAM arbiter: FSM state encoding,
//   RAM owner encoding and default bus widths.
package ram_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH   = 11;
    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_GUARD_CYCLES = 1;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PARK    = 2'd1,
        GRANT   = 2'd2,
        RESTORE = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_CPU  = 2'd0,
        OWN_VGA  = 2'd1,
        OWN_UART = 2'd2
    } owner_t;

endpackage

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Owns the single system RAM port and shares it between the 6502 core,
//   the VGA screen fetcher and the UART program loader. The CPU is only
//   halted at an opcode fetch (or while held in reset), a guard period
//   separates CPU park from the master grant, and one RESTORE cycle
//   re-presents the CPU address to RAM before RDY is released.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   RUN     | CPU owns RAM, RDY high unless a park is being requested
//   PARK    | CPU frozen, nobody writes; owner latched on the last cycle
//   GRANT   | VGA or UART owns RAM, its grant is high
//   RESTORE | CPU address re-read so read data is valid when RDY rises
//
// Ports
//   clk, reset               : 25 MHz system clock, async active-high reset
//   cpu_*                    : 6502 bus (address, write data/enable, SYNC,
//                              held-in-reset) and the RDY returned to it
//   vga_req/addr/grant       : screen fetch, read-only
//   uart_req/addr/wdata/we   : program loader, write-only; uart_grant back
//   ram_*                    : to generic_ram (synchronous read, 1 cycle)
//   lost_write               : sticky flag, loader wrote without a grant
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int GUARD_CYCLES = DEF_GUARD_CYCLES   // 1..3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_we,
    input  logic                  cpu_sync,
    input  logic                  cpu_held,
    output logic                  cpu_rdy,
    input  logic                  vga_req,
    input  logic [ADDR_WIDTH-1:0] vga_addr,
    output logic                  vga_grant,
    input  logic                  uart_req,
    input  logic [ADDR_WIDTH-1:0] uart_addr,
    input  logic [DATA_WIDTH-1:0] uart_wdata,
    input  logic                  uart_we,
    output logic                  uart_grant,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    output logic                  lost_write
);

    localparam logic [1:0] GUARD_LOAD = 2'(GUARD_CYCLES - 1);

    arb_state_t state;
    owner_t     owner;
    logic [1:0] guard_cnt;
    logic       any_req;
    logic       park_req;

    assign any_req  = vga_req | uart_req;
    assign park_req = any_req & (cpu_sync | cpu_held);

    // Combinational so the CPU freezes in the very cycle it shows the
    // opcode address; that address is then the one RESTORE re-reads.
    assign cpu_rdy = (state == RUN) && !park_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RESTORE;
            owner      <= OWN_CPU;
            guard_cnt  <= 2'd0;
            vga_grant  <= 1'b0;
            uart_grant <= 1'b0;
            lost_write <= 1'b0;
        end else begin
            if (uart_we && !uart_grant)
                lost_write <= 1'b1;

            case (state)
                RUN: begin
                    if (park_req) begin
                        state     <= PARK;
                        guard_cnt <= GUARD_LOAD;
                    end
                end
                PARK: begin
                    if (guard_cnt == 2'd0) begin
                        if (uart_req) begin
                            owner      <= OWN_UART;
                            uart_grant <= 1'b1;
                            state      <= GRANT;
                        end else if (vga_req) begin
                            owner     <= OWN_VGA;
                            vga_grant <= 1'b1;
                            state     <= GRANT;
                        end else begin
                            owner <= OWN_CPU;
                            state <= RESTORE;
                        end
                    end else begin
                        guard_cnt <= guard_cnt - 2'd1;
                    end
                end
                GRANT: begin
                    // On hand-over between masters a single PARK cycle
                    // keeps both grants low, independent of GUARD_CYCLES.
                    if (owner == OWN_UART && !uart_req) begin
                        uart_grant <= 1'b0;
                        owner      <= OWN_CPU;
                        guard_cnt  <= 2'd0;
                        state      <= vga_req ? PARK : RESTORE;
                    end else if (owner == OWN_VGA && !vga_req) begin
                        vga_grant <= 1'b0;
                        owner     <= OWN_CPU;
                        guard_cnt <= 2'd0;
                        state     <= uart_req ? PARK : RESTORE;
                    end else if (owner == OWN_CPU) begin
                        vga_grant  <= 1'b0;
                        uart_grant <= 1'b0;
                        state      <= RESTORE;
                    end
                end
                RESTORE: begin
                    state <= RUN;
                end
                default: begin
                    state <= RESTORE;
                end
            endcase
        end
    end

    always_comb begin
        ram_raddr = cpu_addr;
        ram_waddr = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = 1'b0;
        if (state == RUN) begin
            ram_we = cpu_we & cpu_rdy;
        end else if (state == GRANT) begin
            case (owner)
                OWN_VGA: begin
                    ram_raddr = vga_addr;
                    ram_waddr = vga_addr;
                end
                OWN_UART: begin
                    ram_raddr = uart_addr;
                    ram_waddr = uart_addr;
                    ram_wdata = uart_wdata;
                    ram_we    = uart_we & uart_grant;
                end
                default: begin
                    ram_we = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Directed bench for ram_arbiter. The stimulus process drives inputs just
//   after each rising edge and queues the outputs expected for that cycle;
//   a monitor pops one entry per falling edge and compares. A behavioural
//   generic_ram (1-cycle synchronous read) sits on the RAM port; unwritten
//   locations read back a fixed address pattern.
module tb_ram_arbiter;

    typedef struct {
        string name;
        logic  rdy;
        logic  vg;
        logic  ug;
        logic  we;
        logic  lw;
        int    raddr;   // -1: not checked
        int    rdata;   // -1: not checked
    } exp_t;

    logic        clk;
    logic        reset;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic        cpu_sync;
    logic        cpu_held;
    logic        cpu_rdy;
    logic        vga_req;
    logic [10:0] vga_addr;
    logic        vga_grant;
    logic        uart_req;
    logic [10:0] uart_addr;
    logic [7:0]  uart_wdata;
    logic        uart_we;
    logic        uart_grant;
    logic [10:0] ram_raddr;
    logic [10:0] ram_waddr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic        lost_write;
    logic [7:0]  ram_rdata;

    logic [7:0]  mem     [0:2047];
    logic        written [0:2047];

    exp_t q[$];
    int   n_checks;
    int   n_pass;

    ram_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_we     (cpu_we),
        .cpu_sync   (cpu_sync),
        .cpu_held   (cpu_held),
        .cpu_rdy    (cpu_rdy),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_grant  (vga_grant),
        .uart_req   (uart_req),
        .uart_addr  (uart_addr),
        .uart_wdata (uart_wdata),
        .uart_we    (uart_we),
        .uart_grant (uart_grant),
        .ram_raddr  (ram_raddr),
        .ram_waddr  (ram_waddr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .lost_write (lost_write)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    function automatic logic [7:0] pat(input int a);
        return 8'(a) ^ 8'h5A;
    endfunction

    initial begin
        for (int i = 0; i < 2048; i++) begin
            written[i] = 1'b0;
            mem[i]     = 8'h00;
        end
    end

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr]     <= ram_wdata;
            written[ram_waddr] <= 1'b1;
        end
        ram_rdata <= written[ram_raddr] ? mem[ram_raddr] : pat(int'(ram_raddr));
    end

    task automatic chk(input string n, input string f, input int act, input int exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s.%s got 0x%0h want 0x%0h", n, f, act, exp);
        else
            n_pass++;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "cpu_rdy",    int'(cpu_rdy),    int'(e.rdy));
            chk(e.name, "vga_grant",  int'(vga_grant),  int'(e.vg));
            chk(e.name, "uart_grant", int'(uart_grant), int'(e.ug));
            chk(e.name, "ram_we",     int'(ram_we),     int'(e.we));
            chk(e.name, "lost_write", int'(lost_write), int'(e.lw));
            if (e.raddr >= 0) chk(e.name, "ram_raddr", int'(ram_raddr), e.raddr);
            if (e.rdata >= 0) chk(e.name, "ram_rdata", int'(ram_rdata), e.rdata);
        end
    end

    // Queue this cycle's expectation, then move to just after the next edge.
    task automatic step(input string n, input logic rdy, input logic vg, input logic ug,
                        input logic we, input logic lw, input int raddr, input int rdata);
        exp_t e;
        e.name = n; e.rdy = rdy; e.vg = vg; e.ug = ug; e.we = we; e.lw = lw;
        e.raddr = raddr; e.rdata = rdata;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_pass = 0;
        reset = 1'b1;
        cpu_addr = 11'h010; cpu_wdata = 8'h00; cpu_we = 1'b0;
        cpu_sync = 1'b0; cpu_held = 1'b0;
        vga_req = 1'b0; vga_addr = 11'h3FF;
        uart_req = 1'b0; uart_addr = 11'h600; uart_wdata = 8'hA9; uart_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // reset state and release through RESTORE
        step("rst",        0, 0, 0, 0, 0, 'h010, -1);
        reset = 1'b0;
        step("rel_restore", 0, 0, 0, 0, 0, 'h010, -1);
        step("run0",       1, 0, 0, 0, 0, 'h010, int'(pat('h010)));

        // CPU write in RUN is committed the same cycle
        cpu_addr = 11'h200; cpu_wdata = 8'h05; cpu_we = 1'b1;
        step("cpu_wr",     1, 0, 0, 1, 0, 'h200, -1);
        cpu_we = 1'b0;
        step("cpu_rd0",    1, 0, 0, 0, 0, 'h200, -1);
        step("cpu_rd1",    1, 0, 0, 0, 0, 'h200, 'h05);

        // VGA request waits for SYNC
        vga_req = 1'b1; cpu_addr = 11'h021;
        step("vga_nosync", 1, 0, 0, 0, 0, 'h021, -1);
        cpu_addr = 11'h022; cpu_sync = 1'b1;
        step("vga_sync",   0, 0, 0, 0, 0, 'h022, -1);
        step("vga_park",   0, 0, 0, 0, 0, 'h022, -1);
        step("vga_grant0", 0, 1, 0, 0, 0, 'h3FF, -1);
        step("vga_grant1", 0, 1, 0, 0, 0, 'h3FF, int'(pat('h3FF)));
        vga_req = 1'b0;
        step("vga_drop",   0, 1, 0, 0, 0, 'h3FF, -1);
        step("vga_restore", 0, 0, 0, 0, 0, 'h022, -1);
        step("vga_run",    1, 0, 0, 0, 0, 'h022, int'(pat('h022)));
        cpu_sync = 1'b0;

        // both requests: UART wins, then hand-over to VGA via one idle cycle
        cpu_addr = 11'h030; cpu_sync = 1'b1; vga_req = 1'b1; uart_req = 1'b1;
        step("both_sync",  0, 0, 0, 0, 0, 'h030, -1);
        step("both_park",  0, 0, 0, 0, 0, 'h030, -1);
        uart_we = 1'b1;
        step("uart_wr",    0, 0, 1, 1, 0, 'h600, -1);
        uart_we = 1'b0;
        step("uart_rd",    0, 0, 1, 0, 0, 'h600, -1);
        uart_req = 1'b0;
        step("uart_drop",  0, 0, 1, 0, 0, 'h600, 'hA9);
        step("handover",   0, 0, 0, 0, 0, 'h030, -1);
        step("vga_after",  0, 1, 0, 0, 0, 'h3FF, -1);
        vga_req = 1'b0;
        step("vga_drop2",  0, 1, 0, 0, 0, 'h3FF, -1);
        step("restore2",   0, 0, 0, 0, 0, 'h030, -1);
        step("run2",       1, 0, 0, 0, 0, 'h030, -1);

        // held CPU parks without SYNC; unguarded loader write is sticky
        cpu_sync = 1'b0; cpu_held = 1'b1; uart_req = 1'b1;
        step("held_req",   0, 0, 0, 0, 0, 'h030, -1);
        uart_we = 1'b1;
        step("held_park",  0, 0, 0, 0, 0, 'h030, -1);
        uart_we = 1'b0;
        step("held_grant", 0, 0, 1, 0, 1, 'h600, -1);
        uart_req = 1'b0; cpu_held = 1'b0;
        step("held_drop",  0, 0, 1, 0, 1, 'h600, -1);
        step("held_rest",  0, 0, 0, 0, 1, 'h030, -1);
        step("held_run",   1, 0, 0, 0, 1, 'h030, -1);

        // async reset in the middle of a UART grant
        uart_req = 1'b1; cpu_sync = 1'b1;
        step("r_sync",     0, 0, 0, 0, 1, 'h030, -1);
        step("r_park",     0, 0, 0, 0, 1, 'h030, -1);
        uart_we = 1'b1; uart_addr = 11'h601; uart_wdata = 8'h77;
        step("r_grant",    0, 0, 1, 1, 1, 'h601, -1);
        reset = 1'b1;
        step("r_async",    0, 0, 0, 0, 0, 'h030, -1);
        reset = 1'b0; uart_req = 1'b0; uart_we = 1'b0; cpu_sync = 1'b0;
        step("r_restore",  0, 0, 0, 0, 0, 'h030, -1);
        step("r_run",      1, 0, 0, 0, 0, 'h030, -1);

        for (int i = 0; i < 4 && q.size() > 0; i++)
            @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0)
            $display("FAIL drain got %0d pending want 0", q.size());
        else
            n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Owns the single system RAM port and shares it between three masters: the 6502 core, the VGA screen fetcher, and the UART program loader.
- Replaces the ad-hoc cpu_ready/mux logic in the top level.
- Halts the CPU only at an instruction boundary (SYNC), inserts a guard cycle on hand-over, and re-presents the CPU address to RAM one cycle before releasing RDY, so the CPU never samples stale read data.
- Sits between the masters and generic_ram, which has a synchronous read with one-cycle latency.

Parameters:
- ADDR_WIDTH, 11, RAM address width.
- DATA_WIDTH, 8, RAM data width.
- GUARD_CYCLES, 1, idle cycles with no owner between CPU park and master grant (1..3).

Ports:
- clk  in  1  system clock (25 MHz)
- reset  in  1  asynchronous, active-high
- cpu_addr  in  ADDR_WIDTH  CPU address bus (combinational AB)
- cpu_wdata  in  DATA_WIDTH  CPU data out
- cpu_we  in  1  CPU write enable
- cpu_sync  in  1  CPU at opcode fetch
- cpu_held  in  1  CPU held in reset; parking may skip the SYNC wait
- cpu_rdy  out  1  CPU RDY
- vga_req  in  1  screen fetch request (screen_read_en)
- vga_addr  in  ADDR_WIDTH  screen read address
- vga_grant  out  1  VGA owns RAM
- uart_req  in  1  loader request (ask_for_ram)
- uart_addr  in  ADDR_WIDTH  loader write address
- uart_wdata  in  DATA_WIDTH  loader write data
- uart_we  in  1  loader write strobe
- uart_grant  out  1  loader owns RAM
- ram_raddr  out  ADDR_WIDTH  to RAM
- ram_waddr  out  ADDR_WIDTH  to RAM
- ram_wdata  out  DATA_WIDTH  to RAM
- ram_we  out  1  to RAM
- lost_write  out  1  sticky: uart_we seen without uart_grant

Behaviour:
- States: RUN, PARK, GRANT, RESTORE. Encodings live in the package. Reset state is RESTORE.
- Reset values: cpu_rdy=0, vga_grant=0, uart_grant=0, ram_we=0, lost_write=0, owner=CPU, guard counter=0.
- cpu_rdy is combinational: high only in RUN and only when NOT (any_req AND (cpu_sync OR cpu_held)).
  - The CPU therefore freezes in the very cycle it presents the opcode address.
  - any_req = vga_req OR uart_req.
- RUN:
  - RAM mux selects CPU: ram_raddr = ram_waddr = cpu_addr, ram_wdata = cpu_wdata.
  - ram_we = cpu_we AND cpu_rdy.
  - If any_req AND (cpu_sync OR cpu_held), go to PARK.
- PARK:
  - Lasts GUARD_CYCLES cycles.
  - Mux stays on CPU with ram_we=0.
  - Owner is latched on the last PARK cycle. uart_req has priority over vga_req.
  - If any_req has dropped by the last cycle, go to RESTORE instead of GRANT.
- GRANT:
  - Exactly one grant is high, registered, starting the first GRANT cycle.
  - Mux selects the owner's address.
  - ram_we = uart_we only when the owner is UART. VGA is read-only.
  - VGA read data is valid one cycle after vga_addr is presented under grant.
  - When the owner's req drops and the other req is high: switch owner directly. Both grants are low for one cycle (re-enter PARK for one cycle regardless of GUARD_CYCLES).
  - When the owner's req drops and no other req is pending: go to RESTORE.
- RESTORE:
  - Exactly one cycle. Mux on CPU, cpu_rdy=0, ram_we=0. RAM re-reads cpu_addr, so DI is valid when RDY rises.
  - Then go to RUN.
- A request arriving during RESTORE is serviced after RUN is entered. The frozen CPU still shows SYNC, so it re-parks with no instruction progress. This is legal; no corruption.
- No CPU write can be lost: parking happens only at opcode fetch (a read cycle).
- lost_write sets when uart_we=1 and uart_grant=0. It clears only on reset.
- Reset mid-grant: everything returns to reset values immediately (async). The first cycle after release is RESTORE.
- Starvation: none guaranteed for the CPU. The CPU runs whenever no req is high.

Decomposition:
- Package ram_arbiter_pkg holds:
  - state encoding constants (RUN, PARK, GRANT, RESTORE);
  - owner encoding (OWN_CPU, OWN_VGA, OWN_UART);
  - default widths.
- No sub-module. The mux and FSM are one block of about 150–200 lines.

Test Plan:
- Idle CPU run, no req: cpu_rdy held 1, ram_raddr tracks cpu_addr, cpu_we=1 @0x200 data 0x05 → ram_we=1 same cycle.
- vga_req rises while cpu_sync=0 → cpu_rdy stays 1 until the cycle cpu_sync=1, drops that cycle. vga_grant rises after 1 guard cycle. vga_addr=0x3FF appears on ram_raddr.
- vga_req drops → next cycle RESTORE: ram_raddr=cpu_addr, cpu_rdy=0. Following cycle cpu_rdy=1 and ram_rdata equals mem[cpu_addr].
- vga_req and uart_req both high at park → uart_grant wins. uart writes 0xA9 @0x600 committed. After uart_req drops, both grants are low 1 cycle, then vga_grant=1.
- cpu_held=1, uart_req=1, cpu_sync=0 → park without SYNC. uart_we while not granted sets lost_write=1, which stays 1 until reset.
- reset asserted mid-GRANT → grants, ram_we, and cpu_rdy go 0 asynchronously. After release, one RESTORE cycle, then cpu_rdy=1.
